// File: rtl/popcount_share_arb.sv
// popcount_share_arb: round-robin sharing of one popcount datapath between N_REQ CFU requesters
//   clk          clock, all state on posedge
//   rst_n        asynchronous active-low reset
//   req_valid    per-requester request valid
//   req_ready    per-requester request accepted this cycle (one-hot grant)
//   req_data0    per-requester operand, slice i = [i*DATA_W +: DATA_W]
//   resp_valid   per-requester response valid
//   resp_ready   per-requester response consumed
//   resp_status  per-requester CFU status, always CFU_OK (2'b00)
//   resp_data    per-requester popcount, zero-extended; every slice carries the shared result
module popcount_share_arb #(
    parameter int N_REQ = 2,
    parameter int DATA_W = 32,
    parameter bit ADDER_TREE = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*DATA_W-1:0] req_data0,
    output logic [N_REQ-1:0]        resp_valid,
    input  logic [N_REQ-1:0]        resp_ready,
    output logic [N_REQ*2-1:0]      resp_status,
    output logic [N_REQ*DATA_W-1:0] resp_data
);
    localparam int PW = $clog2(N_REQ);
    localparam int CW = 7;
    localparam int NG = (DATA_W + 5) / 6;
    localparam int LV = $clog2(DATA_W);

    if (N_REQ < 2 || N_REQ > 4) begin : g_bad_n_req
        $error("popcount_share_arb: N_REQ must be 2..4");
    end
    if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
        $error("popcount_share_arb: DATA_W must be 32 or 64");
    end

    // (a + b) mod N_REQ for a < N_REQ, b < N_REQ; N_REQ need not be a power of two
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] a, input int b);
        logic [PW:0] s;
        s = {1'b0, a} + (PW+1)'(b);
        return s >= (PW+1)'(N_REQ) ? PW'(s - (PW+1)'(N_REQ)) : PW'(s);
    endfunction

    // 6:3 counters reduce each six-bit group to a 3-bit count, then the counts are summed
    function automatic logic [CW-1:0] pc_compress(input logic [DATA_W-1:0] d);
        logic [NG*6-1:0] p;
        logic [2:0]      c3;
        logic [CW-1:0]   total;
        p = (NG*6)'(d);
        total = '0;
        for (int g = 0; g < NG; g++) begin
            c3 = '0;
            for (int b = 0; b < 6; b++) c3 = c3 + 3'(p[g*6+b]);
            total = total + CW'(c3);
        end
        return total;
    endfunction

    // balanced binary tree; each level folds pairs in place (slot i reads 2i and 2i+1 before they are overwritten)
    function automatic logic [CW-1:0] pc_tree(input logic [DATA_W-1:0] d);
        logic [CW-1:0] s [DATA_W];
        for (int i = 0; i < DATA_W; i++) s[i] = CW'(d[i]);
        for (int l = 0; l < LV; l++)
            for (int i = 0; i < (DATA_W >> (l + 1)); i++) s[i] = s[2*i] + s[2*i+1];
        return s[0];
    endfunction

    logic              r_valid;
    logic [PW-1:0]     r_owner;
    logic [CW-1:0]     r_data;
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     gnt;
    logic              found;
    logic              slot_free;
    logic              acc;
    logic [DATA_W-1:0] opnd;
    logic [CW-1:0]     cnt;

    assign slot_free = !r_valid || resp_ready[r_owner];

    // scan downward so the requester closest to rr_ptr is the last (winning) assignment
    always_comb begin
        found = 1'b0;
        gnt = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid[wrap_add(rr_ptr, k)]) begin
                found = 1'b1;
                gnt = wrap_add(rr_ptr, k);
            end
        end
    end

    // no grant while reset is asserted, even though the async reset already clears state
    assign acc = found && slot_free && rst_n;
    assign opnd = req_data0[gnt*DATA_W +: DATA_W];
    assign cnt = ADDER_TREE ? pc_tree(opnd) : pc_compress(opnd);

    assign req_ready = acc ? N_REQ'(1) << gnt : '0;
    assign resp_valid = r_valid ? N_REQ'(1) << r_owner : '0;
    assign resp_status = '0;
    assign resp_data = {N_REQ{DATA_W'(r_data)}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_owner <= '0;
            r_data <= '0;
            rr_ptr <= '0;
        end else if (acc) begin
            r_valid <= 1'b1;
            r_owner <= gnt;
            r_data <= cnt;
            rr_ptr <= wrap_add(gnt, 1);
        end else if (slot_free) begin
            r_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_popcount_share_arb.sv
// tb_popcount_share_arb: scoreboard bench for both popcount datapath variants sharing one stimulus
module tb_popcount_share_arb;
    localparam int N = 4;
    localparam int W = 64;

    typedef struct {
        int port;
        int cnt;
    } ent_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   resp_ready = '0;
    logic [N*W-1:0] req_data0 = '0;
    logic [N-1:0]   rdy0, rdy1, rv0, rv1;
    logic [N*2-1:0] st0, st1;
    logic [N*W-1:0] rd0, rd1;
    logic [N-1:0]   acc;
    int             vectors = 0;
    int             miscompares = 0;
    ent_t           q0[$];
    ent_t           q1[$];
    int             nxt[2] = '{0, 0};

    always #5 clk = ~clk;

    popcount_share_arb #(.N_REQ(N), .DATA_W(W), .ADDER_TREE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy0), .req_data0(req_data0),
        .resp_valid(rv0), .resp_ready(resp_ready), .resp_status(st0), .resp_data(rd0)
    );
    popcount_share_arb #(.N_REQ(N), .DATA_W(W), .ADDER_TREE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy1), .req_data0(req_data0),
        .resp_valid(rv1), .resp_ready(resp_ready), .resp_status(st1), .resp_data(rd1)
    );

    task automatic cmp(input string nm, input int u, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s u%0d t=%0t: got %0h expected %0h", nm, u, $time, act, exp);
        end
    endtask

    function automatic bit has(input int u);
        return u != 0 ? q1.size() != 0 : q0.size() != 0;
    endfunction

    function automatic ent_t front(input int u);
        return u != 0 ? q1[0] : q0[0];
    endfunction

    // reference: one buffered result, round-robin starting after the last granted port
    task automatic check(input int u, input logic [N-1:0] a_rdy, input logic [N-1:0] a_rv,
                         input logic [N*2-1:0] a_st, input logic [N*W-1:0] a_rd);
        ent_t          e;
        logic [N-1:0]  exp_rv;
        logic [N-1:0]  exp_rdy;
        bit            free;
        int            g;
        exp_rv = '0;
        free = 1'b1;
        if (has(u)) begin
            e = front(u);
            exp_rv[e.port] = 1'b1;
            free = resp_ready[e.port];
            cmp("resp_data", u, a_rd[e.port*W +: W], (N*W)'(e.cnt));
        end
        cmp("resp_valid", u, a_rv, exp_rv);
        cmp("resp_status", u, a_st, '0);
        g = -1;
        if (free)
            for (int k = N - 1; k >= 0; k--)
                if (req_valid[(nxt[u] + k) % N]) g = (nxt[u] + k) % N;
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        cmp("req_ready", u, a_rdy, exp_rdy);
        if (has(u) && resp_ready[e.port]) begin
            if (u != 0) void'(q1.pop_front());
            else void'(q0.pop_front());
        end
        if (g >= 0) begin
            e.port = g;
            e.cnt = $countones(req_data0[g*W +: W]);
            if (u != 0) q1.push_back(e);
            else q0.push_back(e);
            nxt[u] = (g + 1) % N;
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            cmp("rst_resp_valid", 0, rv0, '0);
            cmp("rst_resp_valid", 1, rv1, '0);
            cmp("rst_req_ready", 0, rdy0, '0);
            cmp("rst_req_ready", 1, rdy1, '0);
            cmp("rst_resp_data", 0, rd0, '0);
            cmp("rst_resp_data", 1, rd1, '0);
            q0.delete();
            q1.delete();
            nxt[0] = 0;
            nxt[1] = 0;
        end else begin
            check(0, rdy0, rv0, st0, rd0);
            check(1, rdy1, rv1, st1, rd1);
        end
    end

    function automatic logic [W-1:0] rand_op();
        int k;
        k = $urandom_range(0, 7);
        return k == 0 ? '0 : k == 1 ? '1 : {$urandom, $urandom};
    endfunction

    task automatic tick();
        @(negedge clk);
        acc = req_valid & rdy0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] ops[5];
        int           pvs[4];
        int           prs[4];
        ops = '{64'hFFFF_FFFF, 64'h0, 64'h8000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 64'h5555_5555_5555_5555};
        pvs = '{30, 90, 60, 100};
        prs = '{90, 50, 80, 20};
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        resp_ready = '1;
        foreach (ops[i]) begin
            req_valid = 4'b0001;
            req_data0[W-1:0] = ops[i];
            tick();
        end
        rst_n = 1'b0;
        req_valid = '1;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (12) begin
            for (int p = 0; p < N; p++) req_data0[p*W +: W] = rand_op();
            tick();
        end
        req_valid = 4'b0010;
        req_data0[W +: W] = rand_op();
        tick();
        req_valid = 4'b0001;
        req_data0[W-1:0] = rand_op();
        resp_ready = 4'b1101;
        repeat (5) tick();
        resp_ready = '1;
        tick();
        req_valid = '0;
        tick();
        for (int s = 0; s < 4; s++) begin
            if (s == 2) begin
                rst_n = 1'b0;
                tick();
                tick();
                rst_n = 1'b1;
            end
            repeat (1000) begin
                for (int p = 0; p < N; p++) begin
                    if (!req_valid[p] || acc[p]) begin
                        req_valid[p] = $urandom_range(0, 99) < pvs[s];
                        req_data0[p*W +: W] = rand_op();
                    end
                    resp_ready[p] = $urandom_range(0, 99) < prs[s];
                end
                tick();
            end
        end
        req_valid = '0;
        resp_ready = '1;
        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
